// File: rtl/spi_master_pkg.sv
// Shared definitions for the trigger-board SPI master: FSM encoding, frame geometry, frame builder.
package opentrig_spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD,
        GAP   = ST_GAP
    } spi_state_t;

    localparam int         SPI_FRAME_BITS  = 16;
    localparam int         SPI_WR_FLAG_BIT = 15;
    localparam logic [7:0] SPI_READ_FILL   = 8'h00;

    // {write flag, 7-bit address, data byte}; reads send the fill byte while the peer answers.
    function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic       write,
                                                              input logic [6:0] addr,
                                                              input logic [7:0] wdata);
        logic [SPI_FRAME_BITS-1:0] f;
        f = '0;
        f[SPI_WR_FLAG_BIT] = write;
        f[SPI_WR_FLAG_BIT-1 -: 7] = addr;
        f[7:0] = write ? wdata : SPI_READ_FILL;
        return f;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake between a register client and the SPI master.
interface spi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_master_clk_div.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, held at zero when disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic global_reset_n,
    input  logic en,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 register master: one 16-bit frame per command, second-byte MISO returned on rsp_valid.
// Build option SPI_MISO_SYNC_EN adds a 2-flop MISO synchroniser (requires CLK_DIV >= 3).
module spi_master
    import opentrig_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        global_reset_n,
    spi_master_if.slave cmd,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam logic [9:0] SETUP_LAST = 10'(CS_SETUP - 1);
    localparam logic [9:0] HOLD_LAST  = 10'(CS_HOLD - 1);
    localparam logic [9:0] GAP_END    = 10'(2 * CLK_DIV);
    localparam logic [3:0] LAST_BIT   = 4'(SPI_FRAME_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_master: CLK_DIV must be in 2..255");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1) begin : g_bad_cs
        $error("spi_master: CS_SETUP and CS_HOLD must be at least 1");
    end

    spi_state_t                  state;
    logic [9:0]                  cnt;
    logic [3:0]                  bit_cnt;
    logic [SPI_FRAME_BITS-2:0]   shreg;
    logic [7:0]                  staging;
    logic                        rsp_valid;
    logic [7:0]                  rsp_rdata;
    logic                        busy;
    logic [SPI_FRAME_BITS-1:0]   frame_in;
    logic                        tick;
    logic                        take;
    logic                        capture;
    logic                        miso_s;

    assign frame_in = build_frame(cmd.cmd_write, cmd.cmd_addr, cmd.cmd_wdata);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .en             (state == SHIFT),
        .tick           (tick)
    );

    // Rising edge of spi_clk during the second byte (bit_cnt 8..15).
    assign take = (state == SHIFT) && tick && !spi_clk && bit_cnt[3];

`ifdef SPI_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_sync_div
        $error("spi_master: SPI_MISO_SYNC_EN requires CLK_DIV >= 3");
    end

    logic miso_p1, miso_p2;
    logic take_p1, take_p2;

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            miso_p1 <= 1'b0;
            miso_p2 <= 1'b0;
            take_p1 <= 1'b0;
            take_p2 <= 1'b0;
        end else begin
            miso_p1 <= spi_miso;
            miso_p2 <= miso_p1;
            take_p1 <= take;
            take_p2 <= take_p1;
        end
    end

    assign miso_s  = miso_p2;
    assign capture = take_p2;
`else
    assign miso_s  = spi_miso;
    assign capture = take;
`endif

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            staging   <= '0;
            spi_clk   <= 1'b0;
            spi_cs    <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (capture) begin
                staging <= {staging[6:0], miso_s};
            end
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        shreg    <= frame_in[SPI_FRAME_BITS-2:0];
                        spi_mosi <= frame_in[SPI_FRAME_BITS-1];
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                spi_mosi <= 1'b0;
                                cnt      <= '0;
                                state    <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 4'd1;
                                spi_mosi <= shreg[SPI_FRAME_BITS-2];
                                shreg    <= {shreg[SPI_FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        spi_cs <= 1'b1;
                        cnt    <= '0;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                GAP: begin
                    // The response cycle is still GAP so no command can be accepted alongside it.
                    if (rsp_valid) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == GAP_END) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= staging;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.rsp_valid = rsp_valid;
    assign cmd.rsp_rdata = rsp_rdata;
    assign cmd.busy      = busy;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: fast instance (CLK_DIV=2) plus a slow instance (CLK_DIV=255).
module tb_spi_master;
    logic clk = 1'b0;
    logic global_reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if bus ();
    spi_master_if sbus ();

    logic spi_clk, spi_cs, spi_mosi;
    logic spi_miso = 1'b0;
    logic s_clk, s_cs, s_mosi;
    logic s_miso = 1'b0;

    spi_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk(clk), .global_reset_n(global_reset_n), .cmd(bus.slave),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_master #(.CLK_DIV(255), .CS_SETUP(2), .CS_HOLD(2)) dut_slow (
        .clk(clk), .global_reset_n(global_reset_n), .cmd(sbus.slave),
        .spi_clk(s_clk), .spi_cs(s_cs), .spi_mosi(s_mosi), .spi_miso(s_miso)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Peer model and line monitors for the fast instance.
    logic [15:0] peer_word = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000;
    int rises = 0, mosi_viol = 0, clk_viol = 0, rsp_cnt = 0, cs_run = 0, last_gap = 0;
    logic prev_cs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (!spi_cs && prev_cs) begin
            last_gap = cs_run;
            cs_run   = 0;
            rises    = 0;
            mosi_cap = '0;
            spi_miso = peer_word[15];
        end
        if (spi_cs) cs_run++;
        if (spi_clk && !prev_clk) begin
            if (spi_cs) clk_viol++;
            else begin
                mosi_cap = {mosi_cap[14:0], spi_mosi};
                rises++;
            end
        end
        if (!spi_clk && prev_clk && rises < 16) spi_miso = peer_word[15 - rises];
        if (spi_clk && prev_clk && spi_mosi !== prev_mosi) mosi_viol++;
        if (bus.rsp_valid) rsp_cnt++;
        prev_cs = spi_cs; prev_clk = spi_clk; prev_mosi = spi_mosi;
    end

    // Phase-length and capture monitor for the slow instance.
    logic [15:0] s_cap = 16'h0000;
    int s_rises = 0, s_mosi_viol = 0, s_run = 0;
    int hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
    bit s_started = 1'b0;
    logic s_prev_cs = 1'b1, s_prev_clk = 1'b0, s_prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (!s_cs && s_prev_cs) begin
            s_rises = 0; s_cap = '0; s_started = 1'b0;
        end
        if (s_clk != s_prev_clk) begin
            if (s_started) begin
                if (s_prev_clk) begin
                    if (s_run < hi_min) hi_min = s_run;
                    if (s_run > hi_max) hi_max = s_run;
                end else begin
                    if (s_run < lo_min) lo_min = s_run;
                    if (s_run > lo_max) lo_max = s_run;
                end
            end
            s_started = 1'b1;
            s_run = 1;
            if (s_clk && !s_cs) begin
                s_cap = {s_cap[14:0], s_mosi};
                s_rises++;
            end
        end else begin
            s_run++;
        end
        if (s_clk && s_prev_clk && s_mosi !== s_prev_mosi) s_mosi_viol++;
        s_prev_cs = s_cs; s_prev_clk = s_clk; s_prev_mosi = s_mosi;
    end

    int accept_cyc = 0;

    task automatic send_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int lat, output bit ok);
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = cyc - accept_cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int base;
        bit found;
        global_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.cmd_ready); end
        total++; if (spi_cs !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b want=1", spi_cs); end
        total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL rst_clk got=%b want=0", spi_clk); end
        total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b want=0", spi_mosi); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", bus.rsp_rdata); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        global_reset_n = 1'b1;

        // All-ones frame so MOSI is high when reset hits during bit 5's high phase.
        send_cmd(1'b1, 7'h7F, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rises >= 6) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_reach_bit5 got=%0d rises want=6", rises); end
        total++; if (spi_clk !== 1'b1 || spi_mosi !== 1'b1) begin bad++; $display("FAIL midrst_pre clk=%b mosi=%b want=1/1", spi_clk, spi_mosi); end
        #2 global_reset_n = 1'b0;
        #1;
        total++; if (spi_cs !== 1'b1) begin bad++; $display("FAIL midrst_cs got=%b want=1", spi_cs); end
        total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL midrst_clk got=%b want=0", spi_clk); end
        total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL midrst_mosi got=%b want=0", spi_mosi); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        repeat (2) @(negedge clk);
        global_reset_n = 1'b1;
        base = rsp_cnt;
        repeat (150) @(negedge clk);
        total++; if (rsp_cnt !== base) begin bad++; $display("FAIL midrst_no_rsp got=%0d want=%0d", rsp_cnt, base); end
        total++; if (spi_cs !== 1'b1) begin bad++; $display("FAIL midrst_cs_after got=%b want=1", spi_cs); end
    endtask

    task automatic test_write();
        int lat;
        bit ok;
        peer_word = 16'h0000;
        send_cmd(1'b1, 7'h12, 8'hA5);
        total++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_accept busy=%b ready=%b want=1/0", bus.busy, bus.cmd_ready); end
        total++; if (spi_cs !== 1'b0 || spi_mosi !== 1'b1) begin bad++; $display("FAIL wr_first_bit cs=%b mosi=%b want=0/1", spi_cs, spi_mosi); end
        wait_rsp(200, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_timeout got=none want=rsp_valid"); end
        total++; if (lat !== 73) begin bad++; $display("FAIL wr_latency got=%0d want=73", lat); end
        total++; if (mosi_cap !== 16'h92A5) begin bad++; $display("FAIL wr_mosi got=%h want=92a5", mosi_cap); end
        total++; if (rises !== 16) begin bad++; $display("FAIL wr_rises got=%0d want=16", rises); end
        total++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL wr_rsp_cycle ready=%b busy=%b want=0/1", bus.cmd_ready, bus.busy); end
        @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_after ready=%b busy=%b rv=%b want=1/0/0", bus.cmd_ready, bus.busy, bus.rsp_valid); end
        total++; if (mosi_viol !== 0 || clk_viol !== 0) begin bad++; $display("FAIL wr_line_rules mosi_viol=%0d clk_viol=%0d want=0/0", mosi_viol, clk_viol); end
    endtask

    task automatic test_read();
        int lat;
        bit ok;
        peer_word = 16'hFF3C;
        send_cmd(1'b0, 7'h05, 8'hFF);
        wait_rsp(200, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_timeout got=none want=rsp_valid"); end
        total++; if (lat !== 73) begin bad++; $display("FAIL rd_latency got=%0d want=73", lat); end
        total++; if (mosi_cap !== 16'h0500) begin bad++; $display("FAIL rd_mosi got=%h want=0500", mosi_cap); end
        total++; if (bus.rsp_rdata !== 8'h3C) begin bad++; $display("FAIL rd_data got=%h want=3c", bus.rsp_rdata); end
        repeat (5) @(negedge clk);
        total++; if (bus.rsp_rdata !== 8'h3C) begin bad++; $display("FAIL rd_data_hold got=%h want=3c", bus.rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        peer_word = 16'h0081;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h33; bus.cmd_wdata = 8'h00;
        @(posedge clk);
        #1 accept_cyc = cyc;
        wait_rsp(200, lat, ok);
        total++; if (!ok || lat !== 73) begin bad++; $display("FAIL b2b_first got=%0d want=73", lat); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_rsp got=%b want=0", bus.cmd_ready); end
        @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap ready=%b busy=%b want=1/0", bus.cmd_ready, bus.busy); end
        @(negedge clk);
        accept_cyc = cyc;
        bus.cmd_valid = 1'b0;
        total++; if (bus.busy !== 1'b1 || spi_cs !== 1'b0) begin bad++; $display("FAIL b2b_second_accept busy=%b cs=%b want=1/0", bus.busy, spi_cs); end
        wait_rsp(200, lat, ok);
        total++; if (!ok || lat !== 73) begin bad++; $display("FAIL b2b_second got=%0d want=73", lat); end
        total++; if (bus.rsp_rdata !== 8'h81) begin bad++; $display("FAIL b2b_data got=%h want=81", bus.rsp_rdata); end
        total++; if (mosi_cap !== 16'h3300) begin bad++; $display("FAIL b2b_mosi got=%h want=3300", mosi_cap); end
        total++; if (last_gap < 4) begin bad++; $display("FAIL b2b_cs_gap got=%0d want>=4", last_gap); end
    endtask

    task automatic test_timing();
        int lat;
        bit ok;
        ok = 1'b0;
        lat = -1;
        @(negedge clk);
        sbus.cmd_valid = 1'b1; sbus.cmd_write = 1'b1; sbus.cmd_addr = 7'h2A; sbus.cmd_wdata = 8'h5A;
        @(posedge clk);
        #1 accept_cyc = cyc;
        sbus.cmd_valid = 1'b0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (sbus.rsp_valid) begin lat = cyc - accept_cyc; ok = 1'b1; break; end
        end
        total++; if (!ok || lat !== 8675) begin bad++; $display("FAIL slow_latency got=%0d want=8675", lat); end
        total++; if (s_cap !== 16'hAA5A) begin bad++; $display("FAIL slow_mosi got=%h want=aa5a", s_cap); end
        total++; if (s_rises !== 16) begin bad++; $display("FAIL slow_rises got=%0d want=16", s_rises); end
        total++; if (hi_min !== 255 || hi_max !== 255) begin bad++; $display("FAIL slow_high_phase min=%0d max=%0d want=255", hi_min, hi_max); end
        total++; if (lo_min !== 255 || lo_max !== 255) begin bad++; $display("FAIL slow_low_phase min=%0d max=%0d want=255", lo_min, lo_max); end
        total++; if (s_mosi_viol !== 0) begin bad++; $display("FAIL slow_mosi_stable got=%0d want=0", s_mosi_viol); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        sbus.cmd_valid = 1'b0; sbus.cmd_write = 1'b0; sbus.cmd_addr = '0; sbus.cmd_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
